// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption front end: engine select encoding,
// default start token and the router output FSM states.
package decryption_pkg;

  localparam int unsigned SEL_W       = 2;
  localparam int unsigned NUM_ENGINES = 3;

  localparam logic [SEL_W-1:0] CAESAR_SEL  = 2'd0;
  localparam logic [SEL_W-1:0] SCYTALE_SEL = 2'd1;
  localparam logic [SEL_W-1:0] ZIGZAG_SEL  = 2'd2;
  localparam logic [SEL_W-1:0] DISCARD_SEL = 2'd3;

  localparam logic [7:0] START_DECRYPTION_TOKEN_DEFAULT = 8'hFA;

  typedef enum logic [1:0] {
    FWD,
    WAIT_RISE,
    WAIT_FALL
  } out_state_e;

  // One-hot engine valid for a select value; the discard select maps to none.
  function automatic logic [NUM_ENGINES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_ENGINES-1:0] oh;
    oh = '0;
    case (sel)
      CAESAR_SEL:  oh = 3'b001;
      SCYTALE_SEL: oh = 3'b010;
      ZIGZAG_SEL:  oh = 3'b100;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and count; read data is the
// entry at the registered head pointer.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign do_push = push_i && !full_c;
  assign do_pop  = pop_i && !empty_c;
  assign rdata_c = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy update; a full FIFO refuses a push even alongside a pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/decryption_input_router.sv
// Buffers the incoming character stream, tags each message with the engine
// selected at its first character, and forwards it while honouring engine busy.
module decryption_input_router
  import decryption_pkg::*;
#(
  parameter int unsigned         D_WIDTH                = 8,
  parameter int unsigned         FIFO_DEPTH             = 16,
  parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = D_WIDTH'(START_DECRYPTION_TOKEN_DEFAULT),
  parameter int unsigned         RISE_TIMEOUT           = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   valid_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic                   ready_o,
  input  logic [NUM_ENGINES-1:0] busy_i,
  output logic [D_WIDTH-1:0]     data_o,
  output logic [NUM_ENGINES-1:0] valid_o,
  output logic                   overflow_o
);

  localparam int unsigned ENTRY_W = SEL_W + D_WIDTH;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMR_W   = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;

  logic [ENTRY_W-1:0]     fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   push, pop;
  logic [SEL_W-1:0]       in_tag;
  logic [SEL_W-1:0]       head_tag;
  logic [D_WIDTH-1:0]     head_data;
  logic [3:0]             busy_ext;

  logic                   msg_open_q, msg_open_d;
  logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;
  logic                   overflow_q, overflow_d;
  out_state_e             state_q, state_d;
  logic [SEL_W-1:0]       wait_sel_q, wait_sel_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [D_WIDTH-1:0]     data_q, data_d;
  logic [NUM_ENGINES-1:0] valid_q, valid_d;

  assign ready_o    = (fifo_count < CW'(FIFO_DEPTH));
  assign push       = valid_i && ready_o;
  assign in_tag     = msg_open_q ? cur_sel_q : sel_i;
  assign head_tag   = fifo_rdata[ENTRY_W-1 -: SEL_W];
  assign head_data  = fifo_rdata[D_WIDTH-1:0];
  // Discard select indexes a constant-idle slot so it never stalls.
  assign busy_ext   = {1'b0, busy_i};

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({in_tag, data_i}),
    .pop_i   (pop),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_o (fifo_count)
  );

  // Message framing: select is latched at the first character, token closes it.
  always_comb begin
    msg_open_d = msg_open_q;
    cur_sel_d  = cur_sel_q;
    overflow_d = overflow_q | (valid_i & fifo_full);
    if (push) begin
      if (!msg_open_q) begin
        cur_sel_d  = sel_i;
        msg_open_d = 1'b1;
      end
      if (data_i == START_DECRYPTION_TOKEN) msg_open_d = 1'b0;
    end
  end

  // Output FSM: forward the head, then hold off after a token until the engine's busy pulse.
  always_comb begin
    state_d    = state_q;
    wait_sel_d = wait_sel_q;
    timer_d    = timer_q;
    data_d     = data_q;
    valid_d    = '0;
    pop        = 1'b0;
    case (state_q)
      FWD: begin
        if (!fifo_empty && (head_tag == DISCARD_SEL || !busy_ext[head_tag])) begin
          pop = 1'b1;
          if (head_tag != DISCARD_SEL) begin
            data_d  = head_data;
            valid_d = sel_onehot(head_tag);
            if (head_data == START_DECRYPTION_TOKEN) begin
              wait_sel_d = head_tag;
              timer_d    = '0;
              state_d    = WAIT_RISE;
            end
          end
        end
      end
      WAIT_RISE: begin
        if (busy_ext[wait_sel_q]) begin
          state_d = WAIT_FALL;
        end else if (timer_q == TMR_W'(RISE_TIMEOUT - 1)) begin
          state_d = FWD;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_FALL: begin
        if (!busy_ext[wait_sel_q]) state_d = FWD;
      end
      default: state_d = FWD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_open_q <= 1'b0;
      cur_sel_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= FWD;
      wait_sel_q <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      valid_q    <= '0;
    end else begin
      msg_open_q <= msg_open_d;
      cur_sel_q  <= cur_sel_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      wait_sel_q <= wait_sel_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_decryption_input_router.sv
// Directed bench for decryption_input_router: routing, busy handshake, rise
// timeout, sticky select, overflow, discard and reset.
module tb_decryption_input_router;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [1:0] sel_i;
  logic       ready_o;
  logic [2:0] busy_i;
  logic [7:0] data_o;
  logic [2:0] valid_o;
  logic       overflow_o;

  int errors = 0;
  int checks = 0;

  decryption_input_router dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .sel_i      (sel_i),
    .ready_o    (ready_o),
    .busy_i     (busy_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; sel_i = '0; busy_i = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
  endtask

  // Non-selected engines are held busy to show they do not stall the stream.
  task automatic test_basic_routing();
    logic [7:0] msg [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'hFA};
    busy_i = 3'b011; sel_i = 2'd2;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin valid_i = 1'b1; data_i = msg[i]; end
      else valid_i = 1'b0;
      tick();
      if (i == 0) begin
        checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL basic_latency: got %b expected 000", valid_o); end
      end else begin
        checks++;
        if (valid_o !== 3'b100 || data_o !== msg[i-1]) begin
          errors++; $display("FAIL basic_out%0d: got %b/%h expected 100/%h", i-1, valid_o, data_o, msg[i-1]);
        end
      end
    end
    tick();
    checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL basic_after: got %b expected 000", valid_o); end
    busy_i = 3'b000;
    idle(5);
  endtask

  task automatic test_busy_handshake();
    int seen;
    logic [7:0] msg [4] = '{8'h20, 8'hFA, 8'h10, 8'hFA};
    logic [1:0] sel [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
    busy_i = 3'b000;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = msg[i]; sel_i = sel[i];
      tick();
    end
    // Token of message 1 went out on the third edge; busy starts a cycle later.
    valid_i = 1'b0; busy_i = 3'b100;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL busy_stall%0d: got %b expected 000", i, valid_o); end
    end
    busy_i = 3'b000;
    seen = 0;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      tick();
      if (valid_o !== 3'b000) seen = 1;
    end
    checks++;
    if (valid_o !== 3'b001 || data_o !== 8'h10) begin
      errors++; $display("FAIL busy_release: got %b/%h expected 001/10", valid_o, data_o);
    end
    tick();
    checks++;
    if (valid_o !== 3'b001 || data_o !== 8'hFA) begin
      errors++; $display("FAIL busy_token2: got %b/%h expected 001/fa", valid_o, data_o);
    end
    idle(6);
  endtask

  // Second message waits out the full rise timeout: 66 appears 5 cycles after the first FA.
  task automatic test_rise_timeout();
    logic [7:0] msg [4]  = '{8'h55, 8'hFA, 8'h66, 8'hFA};
    logic [2:0] ev  [10] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
    logic [7:0] ed  [10] = '{8'h00, 8'h55, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h66, 8'hFA, 8'h00};
    busy_i = 3'b000; sel_i = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin valid_i = 1'b1; data_i = msg[i]; end
      else valid_i = 1'b0;
      tick();
      checks++;
      if (valid_o !== ev[i] || (ev[i] != 3'b000 && data_o !== ed[i])) begin
        errors++; $display("FAIL timeout_cyc%0d: got %b/%h expected %b/%h", i, valid_o, data_o, ev[i], ed[i]);
      end
    end
    idle(6);
  endtask

  task automatic test_sticky_select();
    logic [7:0] msg [3] = '{8'h31, 8'h32, 8'hFA};
    logic [1:0] sel [3] = '{2'd1, 2'd2, 2'd2};
    busy_i = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin valid_i = 1'b1; data_i = msg[i]; sel_i = sel[i]; end
      else valid_i = 1'b0;
      tick();
      if (i > 0) begin
        checks++;
        if (valid_o !== 3'b010 || data_o !== msg[i-1]) begin
          errors++; $display("FAIL sticky_out%0d: got %b/%h expected 010/%h", i-1, valid_o, data_o, msg[i-1]);
        end
      end
    end
    idle(6);
  endtask

  task automatic test_overflow();
    int k;
    busy_i = 3'b010; sel_i = 2'd1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ovf_ready%0d: got %b expected 1", i, ready_o); end
      valid_i = 1'b1; data_i = 8'(8'h60 + i);
      tick();
    end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ovf_full: got %b expected 0", ready_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow_o); end
    data_i = 8'h70;
    tick();
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
    checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL ovf_stalled: got %b expected 000", valid_o); end
    valid_i = 1'b0; busy_i = 3'b000;
    k = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (valid_o !== 3'b000) begin
        checks++;
        if (valid_o !== 3'b010 || data_o !== 8'(8'h60 + k)) begin
          errors++; $display("FAIL ovf_drain%0d: got %b/%h expected 010/%h", k, valid_o, data_o, 8'(8'h60 + k));
        end
        k++;
      end
    end
    checks++; if (k !== 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", k); end
    // Close the still-open message so later tests start with a fresh select.
    valid_i = 1'b1; data_i = 8'hFA;
    tick();
    idle(8);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_discard_and_reset();
    logic [7:0] msg [4] = '{8'h71, 8'h72, 8'h73, 8'hFA};
    busy_i = 3'b000; sel_i = 2'd3;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin valid_i = 1'b1; data_i = msg[i]; end
      else valid_i = 1'b0;
      tick();
      checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL discard_cyc%0d: got %b expected 000", i, valid_o); end
    end
    // Empty FIFO and no wait state: a new message keeps single-cycle latency.
    sel_i = 2'd0; valid_i = 1'b1; data_i = 8'h11;
    tick();
    data_i = 8'hFA;
    tick();
    checks++;
    if (valid_o !== 3'b001 || data_o !== 8'h11) begin
      errors++; $display("FAIL discard_next: got %b/%h expected 001/11", valid_o, data_o);
    end
    idle(7);

    busy_i = 3'b100; sel_i = 2'd2;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h81 + i);
      tick();
    end
    valid_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; busy_i = 3'b000;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst2_ready: got %b expected 1", ready_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst2_overflow: got %b expected 0", overflow_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst2_data: got %h expected 00", data_o); end
    sel_i = 2'd1; valid_i = 1'b1; data_i = 8'h91;
    tick();
    checks++; if (valid_o !== 3'b000) begin errors++; $display("FAIL rst2_empty: got %b expected 000", valid_o); end
    data_i = 8'hFA;
    tick();
    checks++;
    if (valid_o !== 3'b010 || data_o !== 8'h91) begin
      errors++; $display("FAIL rst2_fresh: got %b/%h expected 010/91", valid_o, data_o);
    end
    idle(7);
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_busy_handshake();
    test_rise_timeout();
    test_sticky_select();
    test_overflow();
    test_discard_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
